// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates RISC-V conditional branches from the ALU
// subtraction flags and resolves JAL/JALR targets. It issues a registered
// redirect to fetch over a valid/ready handshake, then holds a pipeline
// flush for FLUSH_CYCLES cycles. Fetch predicts not-taken, so every taken
// branch or jump produces a redirect.
module branch_resolve_unit #(
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic [2:0]       ex_funct3,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic [PC_W-1:0]  ex_imm,
   input  logic             ex_jalr,
   input  logic [PC_W-1:0]  ex_jalr_base,
   input  logic             CF,
   input  logic             ZF,
   input  logic             SF,
   input  logic             OF,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   input  logic             redirect_ready,
   output logic             flush,
   output logic             illegal_br,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // Counter only needs to hold FLUSH_CYCLES-1 down to 0.
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_t            state_q, state_d;
   logic [FC_W-1:0]   flush_cnt_q;
   logic [PC_W-1:0]   redirect_pc_q;
   logic              illegal_q;
   logic [CNT_W-1:0]  br_count_q;
   logic [CNT_W-1:0]  taken_count_q;

   logic              accept;
   logic              is_cond_branch;
   logic              cond_true;
   logic              is_illegal;
   logic              taken;
   logic              handshake;
   logic [PC_W-1:0]   target;

   assign accept         = ex_valid & ex_ready;
   // A jump flag overrides a simultaneous branch flag.
   assign is_cond_branch = ex_is_branch & ~ex_is_jump;
   assign is_illegal     = (ex_funct3 == 3'b010) || (ex_funct3 == 3'b011);
   assign taken          = ex_is_jump | (is_cond_branch & cond_true);
   assign handshake      = (state_q == REDIRECT) & redirect_ready;

   // JALR target has bit 0 cleared; branches and JAL are PC-relative.
   assign target = (ex_is_jump & ex_jalr) ? (ex_jalr_base & ~PC_W'(1))
                                          : (ex_pc + ex_imm);

   // Branch condition decode from the rs1-rs2 subtraction flags (CF=1: no borrow).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cond_true = 1'b0;
      case (ex_funct3)
         3'b000:  cond_true = ZF;
         3'b001:  cond_true = ~ZF;
         3'b100:  cond_true = SF ^ OF;
         3'b101:  cond_true = ~(SF ^ OF);
         3'b110:  cond_true = ~CF;
         3'b111:  cond_true = CF;
         default: cond_true = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept && taken)        state_d = REDIRECT;
         REDIRECT: if (redirect_ready)         state_d = FLUSH;
         FLUSH:    if (flush_cnt_q == '0)      state_d = IDLE;
         default:                              state_d = IDLE;
      endcase
   end

   // Redirect target, flush down-counter and illegal-funct3 pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_pc_q <= '0;
         flush_cnt_q   <= '0;
         illegal_q     <= 1'b0;
      end else begin
         if ((state_q == IDLE) && accept && taken)
            redirect_pc_q <= target;
         if (handshake)
            flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
         else if ((state_q == FLUSH) && (flush_cnt_q != '0))
            flush_cnt_q <= flush_cnt_q - 1'b1;
         illegal_q <= accept & is_cond_branch & is_illegal;
      end
   end

   // Statistics counters, wrapping modulo 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count_q    <= '0;
         taken_count_q <= '0;
      end else begin
         if (accept && is_cond_branch) br_count_q    <= br_count_q + 1'b1;
         if (handshake)                taken_count_q <= taken_count_q + 1'b1;
      end
   end

   assign ex_ready       = (state_q == IDLE);
   assign redirect_valid = (state_q == REDIRECT);
   assign flush          = (state_q == FLUSH);
   assign redirect_pc    = redirect_pc_q;
   assign illegal_br     = illegal_q;
   assign br_count       = br_count_q;
   assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit. A second instance with 3-bit counters
// shares the stimulus so counter wrap-around is observable quickly.
module tb_branch_resolve_unit;

   localparam int PC_W = 32;
   localparam int FLUSH_CYCLES = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            ex_valid, ex_is_branch, ex_is_jump, ex_jalr;
   logic [2:0]      ex_funct3;
   logic [PC_W-1:0] ex_pc, ex_imm, ex_jalr_base;
   logic            cf, zf, sf, of_f;
   logic            redirect_ready;

   logic            ex_ready, redirect_valid, flush, illegal_br;
   logic [PC_W-1:0] redirect_pc;
   logic [31:0]     br_count, taken_count;

   logic            s_ex_ready, s_redirect_valid, s_flush, s_illegal_br;
   logic [PC_W-1:0] s_redirect_pc;
   logic [2:0]      s_br_count, s_taken_count;

   int checks = 0;
   int errors = 0;
   int unsigned m_br = 0;
   int unsigned m_taken = 0;

   branch_resolve_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_jalr(ex_jalr), .ex_jalr_base(ex_jalr_base),
      .CF(cf), .ZF(zf), .SF(sf), .OF(of_f),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .flush(flush), .illegal_br(illegal_br),
      .br_count(br_count), .taken_count(taken_count));

   branch_resolve_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(3)) dut_small (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(s_ex_ready),
      .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_jalr(ex_jalr), .ex_jalr_base(ex_jalr_base),
      .CF(cf), .ZF(zf), .SF(sf), .OF(of_f),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
      .redirect_ready(redirect_ready), .flush(s_flush), .illegal_br(s_illegal_br),
      .br_count(s_br_count), .taken_count(s_taken_count));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ALU SUB flag generation for rs1 - rs2.
   task automatic alu_flags(input logic [31:0] rs1, input logic [31:0] rs2,
                            output logic c, output logic z, output logic s, output logic o);
      logic [32:0] diff;
      diff = {1'b0, rs1} - {1'b0, rs2};
      c = ~diff[32];
      z = (diff[31:0] == 32'd0);
      s = diff[31];
      o = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
   endtask

   // Branch outcome from the source operands directly.
   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] rs1,
                                      input logic [31:0] rs2);
      case (f3)
         3'd0:    return rs1 == rs2;
         3'd1:    return rs1 != rs2;
         3'd4:    return $signed(rs1) < $signed(rs2);
         3'd5:    return $signed(rs1) >= $signed(rs2);
         3'd6:    return rs1 < rs2;
         3'd7:    return rs1 >= rs2;
         default: return 1'b0;
      endcase
   endfunction

   // Issue one instruction from IDLE and follow it through redirect and flush.
   task automatic run_instr(input logic br, input logic jmp, input logic [2:0] f3,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic jalr, input logic [31:0] base,
                            input logic c, input logic z, input logic s, input logic o,
                            input logic exp_taken, input int dly, input string tag);
      logic [31:0] exp_pc;
      logic        exp_ill;
      exp_pc  = (jmp && jalr) ? {base[31:1], 1'b0} : pc + imm;
      exp_ill = br && !jmp && (f3 == 3'd2 || f3 == 3'd3);
      checks++;
      if (ex_ready !== 1'b1) begin
         errors++; $display("FAIL %s ex_ready_before got %0b exp 1", tag, ex_ready);
      end
      ex_valid = 1'b1; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
      ex_pc = pc; ex_imm = imm; ex_jalr = jalr; ex_jalr_base = base;
      cf = c; zf = z; sf = s; of_f = o;
      redirect_ready = 1'($urandom_range(0, 1));
      tick();
      ex_valid = 1'b0; ex_funct3 = 3'($urandom); cf = 1'($urandom); zf = 1'($urandom);
      redirect_ready = 1'b0;
      if (br && !jmp) m_br++;
      checks += 4;
      if (redirect_valid !== exp_taken) begin
         errors++; $display("FAIL %s redirect_valid got %0b exp %0b", tag, redirect_valid, exp_taken);
      end
      if (illegal_br !== exp_ill) begin
         errors++; $display("FAIL %s illegal_br got %0b exp %0b", tag, illegal_br, exp_ill);
      end
      if (br_count !== m_br) begin
         errors++; $display("FAIL %s br_count got %0h exp %0h", tag, br_count, m_br);
      end
      if (s_br_count !== m_br[2:0]) begin
         errors++; $display("FAIL %s br_count_wrap got %0d exp %0d", tag, s_br_count, m_br[2:0]);
      end
      if (exp_taken) begin
         checks++;
         if (redirect_pc !== exp_pc) begin
            errors++; $display("FAIL %s redirect_pc got %0h exp %0h", tag, redirect_pc, exp_pc);
         end
         for (int i = 0; i < dly; i++) begin
            tick();
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc || ex_ready !== 1'b0 || flush !== 1'b0) begin
               errors++;
               $display("FAIL %s hold_cycle%0d got rv=%0b pc=%0h rdy=%0b fl=%0b exp rv=1 pc=%0h rdy=0 fl=0",
                        tag, i, redirect_valid, redirect_pc, ex_ready, flush, exp_pc);
            end
         end
         redirect_ready = 1'b1;
         tick();
         redirect_ready = 1'b0;
         m_taken++;
         checks += 2;
         if (flush !== 1'b1 || redirect_valid !== 1'b0 || ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s flush_start got fl=%0b rv=%0b rdy=%0b exp fl=1 rv=0 rdy=0",
                     tag, flush, redirect_valid, ex_ready);
         end
         if (taken_count !== m_taken || s_taken_count !== m_taken[2:0]) begin
            errors++;
            $display("FAIL %s taken_count got %0d/%0d exp %0d/%0d", tag, taken_count,
                     s_taken_count, m_taken, m_taken[2:0]);
         end
         for (int i = 1; i < FLUSH_CYCLES; i++) begin
            tick();
            checks++;
            if (flush !== 1'b1) begin
               errors++; $display("FAIL %s flush_hold%0d got %0b exp 1", tag, i, flush);
            end
         end
         tick();
         checks++;
         if (flush !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL %s flush_end got fl=%0b rdy=%0b exp fl=0 rdy=1", tag, flush, ex_ready);
         end
      end else begin
         tick();
         checks++;
         if (illegal_br !== 1'b0 || redirect_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s not_taken_after got ill=%0b rv=%0b rdy=%0b exp ill=0 rv=0 rdy=1",
                     tag, illegal_br, redirect_valid, ex_ready);
         end
      end
   endtask

   // Branch with operands: flags come from the ALU model, outcome from comparison.
   task automatic run_branch(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] pc, input logic [31:0] imm, input string tag);
      logic c, z, s, o;
      alu_flags(rs1, rs2, c, z, s, o);
      run_instr(1'b1, 1'b0, f3, pc, imm, 1'b0, 32'd0, c, z, s, o, ref_taken(f3, rs1, rs2), 0, tag);
   endtask

   task automatic test_reset();
      ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_funct3 = 0; ex_pc = 0; ex_imm = 0;
      ex_jalr = 0; ex_jalr_base = 0; cf = 0; zf = 0; sf = 0; of_f = 0; redirect_ready = 0;
      rst_n = 1'b0;
      #12;
      checks++;
      if (ex_ready !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || flush !== 1'b0 ||
          illegal_br !== 1'b0 || br_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++;
         $display("FAIL reset got rdy=%0b rv=%0b pc=%0h fl=%0b ill=%0b br=%0d tk=%0d exp 1,0,0,0,0,0,0",
                  ex_ready, redirect_valid, redirect_pc, flush, illegal_br, br_count, taken_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_beq();
      run_branch(3'd0, 32'd7, 32'd7, 32'h100, 32'h20, "beq_taken");
      checks++;
      if (taken_count !== 32'd1 || br_count !== 32'd1) begin
         errors++; $display("FAIL beq_counts got tk=%0d br=%0d exp 1 1", taken_count, br_count);
      end
   endtask

   task automatic test_signed();
      run_branch(3'd4, 32'h8000_0000, 32'd1, 32'h200, 32'hFFFF_FFF0, "blt_min");
      run_branch(3'd5, 32'h8000_0000, 32'd1, 32'h200, 32'h40, "bge_min");
   endtask

   task automatic test_unsigned();
      run_branch(3'd6, 32'd1, 32'd2, 32'h300, 32'h8, "bltu");
      run_branch(3'd7, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8, "bgeu_eq_wrap_pc");
   endtask

   task automatic test_flag_sweep();
      logic [2:0] f3_list [6];
      logic       e;
      f3_list = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      foreach (f3_list[k]) begin
         for (int fl = 0; fl < 16; fl++) begin
            logic c, z, s, o;
            {c, z, s, o} = 4'(fl);
            case (f3_list[k])
               3'd0:    e = z;
               3'd1:    e = !z;
               3'd4:    e = s != o;
               3'd5:    e = s == o;
               3'd6:    e = !c;
               default: e = c;
            endcase
            run_instr(1'b1, 1'b0, f3_list[k], 32'h1000, 32'h10, 1'b0, 32'd0, c, z, s, o, e, 0, "sweep");
         end
      end
   endtask

   task automatic test_jalr_stall();
      run_instr(1'b0, 1'b1, 3'd0, 32'h4000, 32'h0, 1'b1, 32'h2003, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 3, "jalr_stall");
      run_instr(1'b1, 1'b1, 3'd0, 32'h500, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1, "jal_over_branch");
   endtask

   task automatic test_illegal();
      run_instr(1'b1, 1'b0, 3'd2, 32'h600, 32'h4, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 0, "illegal_010");
      run_instr(1'b1, 1'b0, 3'd3, 32'h600, 32'h4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                1'b0, 0, "illegal_011");
   endtask

   task automatic test_valid_low();
      ex_valid = 1'b0; ex_is_branch = 1'b1; ex_is_jump = 1'b1; ex_funct3 = 3'd2;
      cf = 1; zf = 1; redirect_ready = 1'b1;
      tick();
      tick();
      redirect_ready = 1'b0;
      checks++;
      if (redirect_valid !== 1'b0 || illegal_br !== 1'b0 || br_count !== m_br ||
          taken_count !== m_taken || flush !== 1'b0) begin
         errors++;
         $display("FAIL valid_low got rv=%0b ill=%0b br=%0d tk=%0d fl=%0b exp 0,0,%0d,%0d,0",
                  redirect_valid, illegal_br, br_count, taken_count, flush, m_br, m_taken);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         int unsigned kind;
         logic [31:0] rs1, rs2;
         logic c, z, s, o;
         kind = $urandom_range(0, 10);
         rs1  = $urandom;
         rs2  = ($urandom_range(0, 3) == 0) ? rs1 : 32'($urandom);
         if ($urandom_range(0, 5) == 0) rs1 = {1'b1, 31'($urandom_range(0, 3))};
         alu_flags(rs1, rs2, c, z, s, o);
         if (kind <= 5)
            run_branch(3'($urandom), rs1, rs2, $urandom, $urandom, "rand_branch");
         else if (kind <= 9)
            run_instr(kind == 9, 1'b1, 3'($urandom), $urandom, $urandom, kind == 8, $urandom,
                      c, z, s, o, 1'b1, $urandom_range(0, 3), "rand_jump");
         else
            run_instr(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 1'b0, $urandom,
                      c, z, s, o, 1'b0, 0, "rand_nop");
      end
   endtask

   task automatic test_counter_wrap();
      while (m_br[2:0] != 3'd7)
         run_branch(3'd0, 32'd1, 32'd2, 32'h700, 32'h4, "wrap_fill");
      run_branch(3'd0, 32'd1, 32'd2, 32'h700, 32'h4, "wrap_last");
      checks++;
      if (s_br_count !== 3'd0) begin
         errors++; $display("FAIL counter_wrap got %0d exp 0", s_br_count);
      end
   endtask

   // Reset mid-REDIRECT and mid-FLUSH must clear outputs without waiting for a clock.
   task automatic test_reset_mid(input logic in_flush, input string tag);
      ex_valid = 1'b1; ex_is_branch = 1'b0; ex_is_jump = 1'b1; ex_jalr = 1'b0;
      ex_pc = 32'h800; ex_imm = 32'h10;
      tick();
      ex_valid = 1'b0;
      if (in_flush) begin
         redirect_ready = 1'b1;
         tick();
         redirect_ready = 1'b0;
      end
      checks++;
      if ((in_flush ? flush : redirect_valid) !== 1'b1) begin
         errors++; $display("FAIL %s pre_reset got 0 exp 1", tag);
      end
      #2 rst_n = 1'b0;
      #1;
      m_br = 0; m_taken = 0;
      checks++;
      if (flush !== 1'b0 || ex_ready !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 ||
          br_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++;
         $display("FAIL %s async_reset got fl=%0b rdy=%0b rv=%0b pc=%0h br=%0d tk=%0d exp 0,1,0,0,0,0",
                  tag, flush, ex_ready, redirect_valid, redirect_pc, br_count, taken_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || ex_ready !== 1'b1) begin
         errors++; $display("FAIL %s after_reset got rv=%0b fl=%0b rdy=%0b exp 0,0,1",
                            tag, redirect_valid, flush, ex_ready);
      end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_signed();
      test_unsigned();
      test_flag_sweep();
      test_jalr_stall();
      test_illegal();
      test_valid_low();
      test_random();
      test_counter_wrap();
      test_reset_mid(1'b1, "reset_in_flush");
      test_reset_mid(1'b0, "reset_in_redirect");
      run_branch(3'd1, 32'd3, 32'd4, 32'h900, 32'h20, "post_reset_bne");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage consumer of the ALU result flags (CF, ZF, SF, OF) produced when the ALU runs SUB (ALU_Ctrl=0001) on rs1/rs2. It evaluates RISC-V conditional branches and JAL/JALR from those flags, and drives a registered redirect to fetch over a valid/ready handshake. It then holds a pipeline flush for a fixed number of cycles. Fetch is static predict-not-taken, so every taken branch or jump redirects.

Parameters:
PC_W, 32, program-counter width
FLUSH_CYCLES, 2, cycles flush stays asserted after redirect is accepted (>=1)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds an instruction this cycle
ex_ready  out  1  unit can accept EX instruction (stall EX when 0)
ex_is_branch  in  1  conditional branch (opcode 1100011)
ex_is_jump  in  1  JAL or JALR
ex_funct3  in  3  branch funct3
ex_pc  in  PC_W  PC of EX instruction
ex_imm  in  PC_W  sign-extended branch/JAL offset
ex_jalr  in  1  jump is JALR
ex_jalr_base  in  PC_W  ALU ADD result rs1+imm for JALR
CF, ZF, SF, OF  in  1 each  ALU flags from rs1-rs2 subtraction
redirect_valid  out  1  new fetch PC available
redirect_pc  out  PC_W  target PC
redirect_ready  in  1  fetch accepts redirect
flush  out  1  kill IF/ID contents
illegal_br  out  1  one-cycle pulse: branch with funct3 010/011
br_count  out  CNT_W  resolved conditional branches
taken_count  out  CNT_W  redirects issued

Behaviour:
- Reset (async, rst_n=0): state IDLE, redirect_valid=0, redirect_pc=0, flush=0, illegal_br=0, both counters 0, ex_ready=1.
- Condition from funct3:
  - 000 BEQ: ZF
  - 001 BNE: ~ZF
  - 100 BLT: SF^OF
  - 101 BGE: ~(SF^OF)
  - 110 BLTU: ~CF
  - 111 BGEU: CF
  - CF=1 means no borrow, i.e. rs1>=rs2 unsigned.
  - 010/011: not taken, illegal_br pulses the next cycle.
- Target:
  - Branch or JAL: ex_pc+ex_imm, modulo 2^PC_W.
  - JALR: ex_jalr_base with bit0 cleared.
- Accept: ex_valid & ex_ready. If ex_is_branch and ex_is_jump are both 1, ex_is_jump wins.
- State machine IDLE / REDIRECT / FLUSH:
  - IDLE: ex_ready=1. On an accepted taken branch or jump, go to REDIRECT next edge with redirect_valid=1 and redirect_pc=target (1-cycle latency). Not-taken or non-branch: stay IDLE, no output change.
  - REDIRECT: ex_ready=0. redirect_valid and redirect_pc held stable until redirect_ready=1. On the handshake edge: redirect_valid->0, flush->1, counter=FLUSH_CYCLES-1, go to FLUSH.
  - FLUSH: ex_ready=0, flush=1. Counter decrements each cycle; at 0, flush->0 and return to IDLE next edge. flush is high for exactly FLUSH_CYCLES cycles.
- redirect_ready while not in REDIRECT is ignored.
- Counters:
  - br_count +1 per accepted ex_is_branch with ex_is_jump=0, including illegal.
  - taken_count +1 per redirect handshake.
  - Both wrap modulo 2^CNT_W, no saturation.
- Reset asserted mid-REDIRECT or mid-FLUSH: all outputs go immediately to reset values; the pending redirect is dropped.
- ex_valid=0: flag and funct3 inputs are ignored.

Test Plan:
- BEQ, ZF=1, ex_pc=0x100, imm=0x20, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x120; handshake; flush high 2 cycles; taken_count=1, br_count=1.
- BLT, SF=0, OF=1 (rs1=0x80000000, rs2=1) -> taken. Same flags on BGE -> not taken, redirect_valid stays 0, br_count increments.
- BLTU, CF=0 -> taken. BGEU, CF=1, ZF=1 -> taken.
- Sweep all six legal funct3 across all 16 flag combinations -> taken decisions match the table above.
- JALR, ex_jalr_base=0x2003 -> redirect_pc=0x2002. redirect_ready held 0 for 3 cycles -> redirect_valid/pc stable and ex_ready=0 throughout; flush begins only after the ready edge.
- funct3=010 -> not taken, illegal_br one-cycle pulse.
- rst_n low during FLUSH -> flush=0 and ex_ready=1 immediately.
- Preload br_count=0xFFFFFFFF, then one branch -> br_count=0.
